// File: rtl/atm_light_frame_ctrl_if.sv
// atm_light_frame_ctrl_if: pixel-beat input stream plus committed atmospheric-light outputs.
interface atm_light_frame_ctrl_if #(
    parameter int PIX_W = 8,
    parameter int INV_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic             in_eof;
    logic [PIX_W-1:0] dark;
    logic [PIX_W-1:0] pix_R;
    logic [PIX_W-1:0] pix_G;
    logic [PIX_W-1:0] pix_B;
    logic [PIX_W-1:0] A_R;
    logic [PIX_W-1:0] A_G;
    logic [PIX_W-1:0] A_B;
    logic [INV_W-1:0] invA_R;
    logic [INV_W-1:0] invA_G;
    logic [INV_W-1:0] invA_B;
    logic             a_valid;
    logic             a_update;
    logic             busy;

    modport master (
        output in_valid, in_sof, in_eof, dark, pix_R, pix_G, pix_B,
        input  in_ready, A_R, A_G, A_B, invA_R, invA_G, invA_B, a_valid, a_update, busy
    );

    modport slave (
        input  in_valid, in_sof, in_eof, dark, pix_R, pix_G, pix_B,
        output in_ready, A_R, A_G, A_B, invA_R, invA_G, invA_B, a_valid, a_update, busy
    );
endinterface

// File: rtl/atm_light_frame_ctrl.sv
// atm_light_frame_ctrl: picks the brightest dark-channel pixel per frame, then commits A and 2^NUM_SHIFT/A.
// Define ATM_LIGHT_IIR_EN to smooth A across frames as (3*A_old + cand + 2) >> 2.
module atm_light_frame_ctrl #(
    parameter int PIX_W     = 8,
    parameter int INV_W     = 9,
    parameter int NUM_SHIFT = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    atm_light_frame_ctrl_if.slave bus
);
    localparam int QW = NUM_SHIFT + 1;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, SCAN, DIV, COMMIT} state_t;

    state_t                  state_q, state_d;
    logic [PIX_W-1:0]        max_q, max_d;
    logic [PIX_W-1:0]        rem_q, rem_d;
    logic [2:0][PIX_W-1:0]   cand_q, cand_d, a_q, a_next, pix;
    logic [2:0][INV_W-1:0]   qt_q, qt_d, inv_q;
    logic [QW-1:0]           quo_q, quo_d, quo_n;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              ch_q, ch_d;
    logic                    a_valid_q, a_update_q, accept, ge;
    logic [PIX_W:0]          shifted, diff;
    logic [PIX_W-1:0]        divisor;
    logic [INV_W-1:0]        quo_sat;

    assign pix          = {bus.pix_B, bus.pix_G, bus.pix_R};
    assign bus.in_ready = (state_q == IDLE) || (state_q == SCAN);
    assign bus.busy     = (state_q == DIV) || (state_q == COMMIT);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ATM_LIGHT_IIR_EN
    logic [2:0][PIX_W+1:0] mix;
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            mix[c]    = {1'b0, a_q[c], 1'b0} + {2'b00, a_q[c]} + {2'b00, cand_q[c]} + (PIX_W+2)'(2);
            a_next[c] = a_valid_q ? mix[c][PIX_W+1:2] : cand_q[c];
        end
    end
`else
    assign a_next = cand_q;
`endif

    // One restoring step per cycle; the dividend 2^NUM_SHIFT contributes a single 1 at the first step.
    assign divisor = a_next[ch_q];
    assign shifted = {rem_q, cnt_q == '0};
    assign ge      = shifted >= {1'b0, divisor};
    assign diff    = shifted - {1'b0, divisor};
    assign quo_n   = {quo_q[QW-2:0], ge};
    assign quo_sat = |quo_n[QW-1:INV_W] ? '1 : quo_n[INV_W-1:0];

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        cand_d  = cand_q;
        qt_d    = qt_q;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        ch_d    = '0;
        if (accept && (bus.in_sof || state_q == SCAN)) begin
            if (bus.in_sof || bus.dark > max_q) begin
                max_d  = bus.dark;
                cand_d = pix;
            end
            state_d = bus.in_eof ? DIV : SCAN;
        end
        if (state_q == DIV) begin
            rem_d = ge ? diff[PIX_W-1:0] : shifted[PIX_W-1:0];
            quo_d = quo_n;
            cnt_d = cnt_q + 1'b1;
            ch_d  = ch_q;
            if (cnt_q == CW'(NUM_SHIFT)) begin
                qt_d[ch_q] = quo_sat;
                rem_d      = '0;
                quo_d      = '0;
                cnt_d      = '0;
                ch_d       = ch_q + 1'b1;
                state_d    = (ch_q == 2'd2) ? COMMIT : DIV;
            end
        end
        if (state_q == COMMIT) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            max_q      <= '0;
            cand_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            ch_q       <= '0;
            qt_q       <= '0;
            a_q        <= '0;
            inv_q      <= '0;
            a_valid_q  <= 1'b0;
            a_update_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            cand_q     <= cand_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            qt_q       <= qt_d;
            a_update_q <= state_q == COMMIT;
            if (state_q == COMMIT) begin
                a_q       <= a_next;
                inv_q     <= qt_q;
                a_valid_q <= 1'b1;
            end
        end
    end

    assign bus.A_R      = a_q[0];
    assign bus.A_G      = a_q[1];
    assign bus.A_B      = a_q[2];
    assign bus.invA_R   = inv_q[0];
    assign bus.invA_G   = inv_q[1];
    assign bus.invA_B   = inv_q[2];
    assign bus.a_valid  = a_valid_q;
    assign bus.a_update = a_update_q;
endmodule

// File: tb/tb_atm_light_frame_ctrl.sv
// tb_atm_light_frame_ctrl: directed frames against hand-computed A / reciprocal values and commit timing.
module tb_atm_light_frame_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    atm_light_frame_ctrl_if #(.PIX_W(8), .INV_W(9)) bus ();

    atm_light_frame_ctrl #(.PIX_W(8), .INV_W(9), .NUM_SHIFT(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input int ar, ag, ab, ir, ig, ib);
        check({tag, "_A_R"}, int'(bus.A_R), ar);
        check({tag, "_A_G"}, int'(bus.A_G), ag);
        check({tag, "_A_B"}, int'(bus.A_B), ab);
        check({tag, "_invA_R"}, int'(bus.invA_R), ir);
        check({tag, "_invA_G"}, int'(bus.invA_G), ig);
        check({tag, "_invA_B"}, int'(bus.invA_B), ib);
    endtask

    task automatic beat(input bit sof, eof, input int d, r, g, b);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_eof   = eof;
        bus.dark     = d[7:0];
        bus.pix_R    = r[7:0];
        bus.pix_G    = g[7:0];
        bus.pix_B    = b[7:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
    endtask

    task automatic do_reset;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_commit(output int lat, output int rdy_hi, output int busy_lo);
        lat = -1;
        rdy_hi = 0;
        busy_lo = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.a_update) begin
                lat = n;
                break;
            end
            if (bus.in_ready) rdy_hi++;
            if (!bus.busy) busy_lo++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, rdy_hi, busy_lo, cnt;
        int dk[5];
        int rs_d[7], rs_r[7], rs_g[7], rs_b[7];
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        bus.dark     = '0;
        bus.pix_R    = '0;
        bus.pix_G    = '0;
        bus.pix_B    = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst", 0, 0, 0, 0, 0, 0);
        check("rst_a_valid", int'(bus.a_valid), 0);
        check("rst_a_update", int'(bus.a_update), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);

        // Uniform frame: latency and handshake around the commit
        for (int i = 0; i < 9; i++) beat(i == 0, i == 8, 100, 100, 120, 140);
        check("u_div_busy", int'(bus.busy), 1);
        check("u_div_ready", int'(bus.in_ready), 0);
        wait_commit(lat, rdy_hi, busy_lo);
        check("u_latency", lat, 52);
        check("u_ready_high_in_div", rdy_hi, 0);
        check("u_busy_low_in_div", busy_lo, 0);
        check_out("u", 100, 120, 140, 511, 511, 468);
        check("u_a_valid", int'(bus.a_valid), 1);
        check("u_busy_after", int'(bus.busy), 0);
        check("u_ready_after", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        check("u_a_update_drop", int'(bus.a_update), 0);
        check("u_hold_A_R", int'(bus.A_R), 100);

        // Strict max: the second 200 must not replace the first
        do_reset();
        dk = '{50, 200, 90, 200, 30};
        for (int i = 0; i < 5; i++) begin
            if (i == 1) beat(i == 0, i == 4, dk[i], 200, 210, 180);
            else if (i == 3) beat(i == 0, i == 4, dk[i], 10, 10, 10);
            else beat(i == 0, i == 4, dk[i], 1, 2, 3);
        end
        wait_commit(lat, rdy_hi, busy_lo);
        check("tie_latency", lat, 52);
        check_out("tie", 200, 210, 180, 327, 312, 364);

        // Mid-frame sof discards the earlier 250
        do_reset();
        rs_d = '{10, 50, 250, 60, 120, 80, 120};
        rs_r = '{1, 1, 9, 2, 220, 3, 1};
        rs_g = '{1, 1, 9, 2, 230, 3, 1};
        rs_b = '{1, 1, 9, 2, 255, 3, 1};
        for (int i = 0; i < 7; i++) beat(i == 0 || i == 3, i == 6, rs_d[i], rs_r[i], rs_g[i], rs_b[i]);
        wait_commit(lat, rdy_hi, busy_lo);
        check("rs_latency", lat, 52);
        check_out("rs", 220, 230, 255, 297, 284, 257);

        // Zero-valued single-beat frame with the next sof held during DIV
        do_reset();
        beat(1'b1, 1'b1, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        bus.in_eof   = 1'b1;
        bus.dark     = 8'd5;
        bus.pix_R    = 8'd100;
        bus.pix_G    = 8'd100;
        bus.pix_B    = 8'd100;
        wait_commit(lat, rdy_hi, busy_lo);
        check("bp_latency", lat, 52);
        check("bp_ready_high_in_div", rdy_hi, 0);
        check_out("bp", 0, 0, 0, 511, 511, 511);
        check("bp_ready_at_commit", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        check("bp_accepted", int'(bus.in_ready), 0);
        check("bp_busy", int'(bus.busy), 1);

        // Async reset in the middle of the second division
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_out("rdiv", 0, 0, 0, 0, 0, 0);
        check("rdiv_a_valid", int'(bus.a_valid), 0);
        check("rdiv_in_ready", int'(bus.in_ready), 1);
        check("rdiv_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (bus.a_update) cnt++;
        end
        check("rdiv_no_update", cnt, 0);
        check("rdiv_A_R_after", int'(bus.A_R), 0);
        check("rdiv_a_valid_after", int'(bus.a_valid), 0);

        // Two consecutive frames: smoothing only when the IIR build is selected
        do_reset();
        beat(1'b1, 1'b1, 200, 200, 200, 200);
        wait_commit(lat, rdy_hi, busy_lo);
        check("iir1_latency", lat, 52);
        check_out("iir1", 200, 200, 200, 327, 327, 327);
        beat(1'b1, 1'b1, 100, 100, 100, 100);
        wait_commit(lat, rdy_hi, busy_lo);
        check("iir2_latency", lat, 52);
`ifdef ATM_LIGHT_IIR_EN
        check_out("iir2", 175, 175, 175, 374, 374, 374);
`else
        check_out("iir2", 100, 100, 100, 511, 511, 511);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
